tt_um_jleugeri_ttt_fanout: RTL and testbench

//  Next-gen connection memory/iterator between the processor array and the token scheduler.

---
 rtl/ttt_pkg.sv | 27 ++
 rtl/tt_um_jleugeri_ttt_conn_mem.sv | 59 +++++
 rtl/tt_um_jleugeri_ttt_fanout.sv | 145 ++++++++++++++
 tb/tb_tt_um_jleugeri_ttt_fanout.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and defaults for the fanout connection memory/iterator.
// Holds the FSM state encoding, the programming opcodes and small width helpers.
package ttt_pkg;

    localparam int DEF_NUM_PROCESSORS  = 8;
    localparam int DEF_NEW_TOKEN_BITS  = 4;
    localparam int DEF_NUM_TOKEN_TYPES = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } fanout_state_e;

    typedef enum logic [1:0] {
        PROG_WEIGHT = 2'd0,
        PROG_INDPTR = 2'd1,
        PROG_INDEX  = 2'd2
    } prog_op_e;

    // Index width that never collapses to zero bits for single-entry selectors.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tt_um_jleugeri_ttt_conn_mem.sv
// Connection storage in CSC form: indptr per processor, target index and per-channel weights
// per connection. One write port, asynchronous read of the indptr pair and one connection entry.
module tt_um_jleugeri_ttt_conn_mem
    import ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS  = DEF_NUM_PROCESSORS,
    parameter int NUM_CONNECTIONS = NUM_PROCESSORS * NUM_PROCESSORS,
    parameter int NEW_TOKEN_BITS  = DEF_NEW_TOKEN_BITS,
    parameter int NUM_TOKEN_TYPES = DEF_NUM_TOKEN_TYPES,
    localparam int PW = $clog2(NUM_PROCESSORS),
    localparam int CW = $clog2(NUM_CONNECTIONS + 1),
    localparam int AW = $clog2(NUM_CONNECTIONS),
    localparam int SW = $clog2(NUM_PROCESSORS + 1),
    localparam int HW = clog2_min1(NUM_TOKEN_TYPES),
    localparam int TW = NUM_TOKEN_TYPES * NEW_TOKEN_BITS
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  prog_op_e                  op_i,
    input  logic [SW-1:0]             wr_pid_i,
    input  logic [CW-1:0]             wr_cid_i,
    input  logic [HW-1:0]             wr_channel_i,
    input  logic [NEW_TOKEN_BITS-1:0] wr_tokens_i,
    input  logic [PW-1:0]             ptr_idx_i,
    output logic [CW-1:0]             ptr_lo_o,
    output logic [CW-1:0]             ptr_hi_o,
    input  logic [AW-1:0]             ent_addr_i,
    output logic [PW-1:0]             ent_target_o,
    output logic [TW-1:0]             ent_tokens_o
);

    logic [CW-1:0]             indptr_mem [NUM_PROCESSORS+1];
    logic [PW-1:0]             index_mem  [NUM_CONNECTIONS];
    logic [NEW_TOKEN_BITS-1:0] weight_mem [NUM_CONNECTIONS][NUM_TOKEN_TYPES];

    // Contents are deliberately not reset; they are defined only once programmed.
    always_ff @(posedge clk) begin
        if (we_i) begin
            case (op_i)
                PROG_WEIGHT: weight_mem[wr_cid_i[AW-1:0]][wr_channel_i] <= wr_tokens_i;
                PROG_INDPTR: indptr_mem[wr_pid_i] <= wr_cid_i;
                PROG_INDEX:  index_mem[wr_cid_i[AW-1:0]] <= wr_pid_i[PW-1:0];
                default: ;
            endcase
        end
    end

    assign ptr_lo_o     = indptr_mem[SW'(ptr_idx_i)];
    assign ptr_hi_o     = indptr_mem[SW'(ptr_idx_i) + SW'(1)];
    assign ent_target_o = index_mem[ent_addr_i];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TOKEN_TYPES; gi++) begin : g_ch
            assign ent_tokens_o[gi*NEW_TOKEN_BITS +: NEW_TOKEN_BITS] = weight_mem[ent_addr_i][gi];
        end
    endgenerate

endmodule

// File: rtl/tt_um_jleugeri_ttt_fanout.sv
// Fanout iterator: on a start request walks the outgoing connections of one processor and
// streams (target, weights) over a valid/ready interface; also owns the programming port.
module tt_um_jleugeri_ttt_fanout
    import ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS  = DEF_NUM_PROCESSORS,
    parameter int NUM_CONNECTIONS = NUM_PROCESSORS * NUM_PROCESSORS,
    parameter int NEW_TOKEN_BITS  = DEF_NEW_TOKEN_BITS,
    parameter int NUM_TOKEN_TYPES = DEF_NUM_TOKEN_TYPES,
    localparam int PW = $clog2(NUM_PROCESSORS),
    localparam int CW = $clog2(NUM_CONNECTIONS + 1),
    localparam int SW = $clog2(NUM_PROCESSORS + 1),
    localparam int HW = clog2_min1(NUM_TOKEN_TYPES),
    localparam int TW = NUM_TOKEN_TYPES * NEW_TOKEN_BITS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic [PW-1:0]             start_pid,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PW-1:0]             out_target_id,
    output logic [TW-1:0]             out_tokens,
    output logic                      done,
    output logic                      range_err,
    input  logic                      prog_en,
    input  logic [1:0]                prog_op,
    input  logic [SW-1:0]             prog_pid,
    input  logic [CW-1:0]             prog_cid,
    input  logic [HW-1:0]             prog_channel,
    input  logic [NEW_TOKEN_BITS-1:0] prog_tokens,
    output logic                      prog_err
);

    localparam int AW = $clog2(NUM_CONNECTIONS);
    localparam logic [CW-1:0] NC_LIMIT = CW'(NUM_CONNECTIONS);
    localparam logic [SW-1:0] NP_LIMIT = SW'(NUM_PROCESSORS);

    fanout_state_e state_q;
    logic [PW-1:0] pid_q;
    logic [CW-1:0] addr_q;
    logic [CW-1:0] end_q;
    logic          out_valid_q;
    logic [PW-1:0] out_target_q;
    logic [TW-1:0] out_tokens_q;
    logic          done_q;
    logic          range_err_q;
    logic          prog_err_q;

    logic [CW-1:0] ptr_lo;
    logic [CW-1:0] ptr_hi;
    logic [PW-1:0] ent_target;
    logic [TW-1:0] ent_tokens;
    logic          prog_bad;
    logic          prog_we;
    logic          advance;

    assign prog_bad    = (prog_cid >= NC_LIMIT) || (prog_pid > NP_LIMIT);
    assign prog_we     = prog_en && (state_q == IDLE) && !prog_bad && (prog_op != 2'd3);
    assign start_ready = (state_q == IDLE) && !prog_en;
    assign advance     = !out_valid_q || out_ready;

    tt_um_jleugeri_ttt_conn_mem #(
        .NUM_PROCESSORS  (NUM_PROCESSORS),
        .NUM_CONNECTIONS (NUM_CONNECTIONS),
        .NEW_TOKEN_BITS  (NEW_TOKEN_BITS),
        .NUM_TOKEN_TYPES (NUM_TOKEN_TYPES)
    ) u_conn_mem (
        .clk          (clk),
        .we_i         (prog_we),
        .op_i         (prog_op_e'(prog_op)),
        .wr_pid_i     (prog_pid),
        .wr_cid_i     (prog_cid),
        .wr_channel_i (prog_channel),
        .wr_tokens_i  (prog_tokens),
        .ptr_idx_i    (pid_q),
        .ptr_lo_o     (ptr_lo),
        .ptr_hi_o     (ptr_hi),
        .ent_addr_i   (addr_q[AW-1:0]),
        .ent_target_o (ent_target),
        .ent_tokens_o (ent_tokens)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pid_q        <= '0;
            addr_q       <= '0;
            end_q        <= '0;
            out_valid_q  <= 1'b0;
            out_target_q <= '0;
            out_tokens_q <= '0;
            done_q       <= 1'b0;
            range_err_q  <= 1'b0;
            prog_err_q   <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
            prog_err_q  <= prog_en && ((state_q != IDLE) || prog_bad);
            case (state_q)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        pid_q   <= start_pid;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    addr_q  <= ptr_lo;
                    end_q   <= ptr_hi;
                    state_q <= STREAM;
                end
                STREAM: begin
                    // The range is judged on the registered pointer pair, so an empty or
                    // inverted range finishes exactly like a fully drained one.
                    if (advance) begin
                        if (end_q > addr_q) begin
                            out_target_q <= ent_target;
                            out_tokens_q <= ent_tokens;
                            out_valid_q  <= 1'b1;
                            addr_q       <= addr_q + CW'(1);
                        end else begin
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            range_err_q <= (end_q < addr_q);
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid     = out_valid_q;
    assign out_target_id = out_target_q;
    assign out_tokens    = out_tokens_q;
    assign done          = done_q;
    assign range_err     = range_err_q;
    assign prog_err      = prog_err_q;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_fanout.sv
// Directed bench for the fanout iterator: programs a small CSC table and checks streams,
// back-pressure, empty/inverted ranges, programming errors and asynchronous reset.
module tb_tt_um_jleugeri_ttt_fanout;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic [2:0] start_pid = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_target_id;
    logic [7:0] out_tokens;
    logic       done;
    logic       range_err;
    logic       prog_en = 1'b0;
    logic [1:0] prog_op = '0;
    logic [3:0] prog_pid = '0;
    logic [6:0] prog_cid = '0;
    logic [0:0] prog_channel = '0;
    logic [3:0] prog_tokens = '0;
    logic       prog_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_tgt [0:2];
    logic [7:0] exp_tok [0:2];

    always #5 clk = ~clk;

    tt_um_jleugeri_ttt_fanout dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .start_pid     (start_pid),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_target_id (out_target_id),
        .out_tokens    (out_tokens),
        .done          (done),
        .range_err     (range_err),
        .prog_en       (prog_en),
        .prog_op       (prog_op),
        .prog_pid      (prog_pid),
        .prog_cid      (prog_cid),
        .prog_channel  (prog_channel),
        .prog_tokens   (prog_tokens),
        .prog_err      (prog_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic prog(input logic [1:0] op, input logic [3:0] pid, input logic [6:0] cid,
                        input logic ch, input logic [3:0] tok, input logic exp_err);
        @(negedge clk);
        prog_en = 1'b1; prog_op = op; prog_pid = pid; prog_cid = cid;
        prog_channel = ch; prog_tokens = tok;
        @(posedge clk); #1;
        prog_en = 1'b0;
        check("prog_err", {31'b0, prog_err}, {31'b0, exp_err});
        $display("prog op=%0d pid=%0d cid=%0d ch=%0d tok=%0h prog_err=%0b", op, pid, cid, ch, tok, prog_err);
    endtask

    // Returns 1 ns after the accepting edge T.
    task automatic start(input logic [2:0] pid);
        @(negedge clk);
        start_pid = pid; start_valid = 1'b1;
        check("start_ready", {31'b0, start_ready}, 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
    endtask

    // Consumer model: cycle c is sampled 1 ns after edge T+c; out_ready decided there applies
    // to edge T+c+1. The entry at index stall_at is refused for stall_cycles cycles.
    task automatic run_pid(input string name, input logic [2:0] pid, input int n_exp,
                           input int stall_at, input int stall_cycles,
                           input logic exp_err, input int exp_done_cyc);
        int k = 0;
        int stalled = 0;
        int first = -1;
        bit done_seen = 0;
        out_ready = 1'b1;
        start(pid);
        for (int c = 1; c <= 40 && !done_seen; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                if (first < 0) first = c;
                if (k >= n_exp) begin
                    check({name, "_extra_out"}, 32'd1, 32'd0);
                end else begin
                    check({name, "_tgt"}, {29'b0, out_target_id}, {29'b0, exp_tgt[k]});
                    check({name, "_tok"}, {24'b0, out_tokens}, {24'b0, exp_tok[k]});
                    $display("%s c=%0d tgt=%0d tok=%02h ready=%0b", name, c, out_target_id, out_tokens,
                             !(k == stall_at && stalled < stall_cycles));
                end
                if (k == stall_at && stalled < stall_cycles) begin
                    out_ready = 1'b0;
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    k++;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (done) begin
                done_seen = 1;
                check({name, "_done_cyc"}, c, exp_done_cyc);
                check({name, "_range_err"}, {31'b0, range_err}, {31'b0, exp_err});
                check({name, "_count"}, k, n_exp);
                $display("%s done at T+%0d range_err=%0b entries=%0d", name, c, range_err, k);
            end
        end
        if (!done_seen) check({name, "_done_timeout"}, 32'd0, 32'd1);
        if (n_exp > 0) check({name, "_first_lat"}, first, 32'd2);
        else check({name, "_no_out"}, first, -1);
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        exp_tgt[0] = 3'd1; exp_tok[0] = 8'hF1;
        exp_tgt[1] = 3'd2; exp_tok[1] = 8'h02;
        exp_tgt[2] = 3'd3; exp_tok[2] = 8'h78;

        #2;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_range_err", {31'b0, range_err}, 32'd0);
        check("rst_prog_err", {31'b0, prog_err}, 32'd0);
        check("rst_target", {29'b0, out_target_id}, 32'd0);
        check("rst_tokens", {24'b0, out_tokens}, 32'd0);
        check("rst_start_ready", {31'b0, start_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Base table: indptr = {0,3,3,5,5,5,5,5,5}
        prog(2'd1, 4'd0, 7'd0, 1'b0, 4'h0, 1'b0);
        prog(2'd1, 4'd1, 7'd3, 1'b0, 4'h0, 1'b0);
        prog(2'd1, 4'd2, 7'd3, 1'b0, 4'h0, 1'b0);
        for (int p = 3; p <= 8; p++) prog(2'd1, 4'(p), 7'd5, 1'b0, 4'h0, 1'b0);
        for (int e = 0; e < 3; e++) begin
            prog(2'd2, {1'b0, exp_tgt[e]}, 7'(e), 1'b0, 4'h0, 1'b0);
            prog(2'd0, 4'd0, 7'(e), 1'b0, exp_tok[e][3:0], 1'b0);
            prog(2'd0, 4'd0, 7'(e), 1'b1, exp_tok[e][7:4], 1'b0);
        end
        prog(2'd2, 4'd5, 7'd3, 1'b0, 4'h0, 1'b0);
        prog(2'd2, 4'd6, 7'd4, 1'b0, 4'h0, 1'b0);

        // Out-of-range addresses are dropped and flagged
        prog(2'd0, 4'd0, 7'd64, 1'b0, 4'h5, 1'b1);
        prog(2'd1, 4'd9, 7'd1, 1'b0, 4'h0, 1'b1);
        prog(2'd1, 4'd8, 7'd5, 1'b0, 4'h0, 1'b0);

        run_pid("t1_full", 3'd0, 3, -1, 0, 1'b0, 5);
        run_pid("t2_empty", 3'd1, 0, -1, 0, 1'b0, 2);
        run_pid("t3_stall", 3'd0, 3, 1, 3, 1'b0, 8);

        // prog and start in the same IDLE cycle: write happens, start is refused
        @(negedge clk);
        prog_en = 1'b1; prog_op = 2'd0; prog_pid = 4'd0; prog_cid = 7'd0;
        prog_channel = 1'b0; prog_tokens = 4'h1;
        start_valid = 1'b1; start_pid = 3'd0;
        #1 check("both_start_ready", {31'b0, start_ready}, 32'd0);
        @(posedge clk); #1;
        prog_en = 1'b0; start_valid = 1'b0;
        check("both_prog_err", {31'b0, prog_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1 check("both_no_stream", {31'b0, out_valid}, 32'd0);
        check("both_idle", {31'b0, start_ready}, 32'd1);
        $display("prog+start same cycle: start_ready=%0b out_valid=%0b", start_ready, out_valid);

        // Test 5: programming while streaming is rejected
        start(3'd0);
        @(negedge clk);
        @(negedge clk);
        prog_en = 1'b1; prog_op = 2'd2; prog_pid = 4'd7; prog_cid = 7'd0;
        @(posedge clk); #1;
        prog_en = 1'b0;
        check("t5_prog_err", {31'b0, prog_err}, 32'd1);
        $display("t5 prog during stream: prog_err=%0b", prog_err);
        for (int c = 0; c < 20 && !done; c++) begin
            @(posedge clk); #1;
        end
        check("t5_done", {31'b0, done}, 32'd1);
        @(posedge clk); #1;
        run_pid("t5_reread", 3'd0, 3, -1, 0, 1'b0, 5);

        // Test 4: inverted range
        prog(2'd1, 4'd2, 7'd4, 1'b0, 4'h0, 1'b0);
        prog(2'd1, 4'd3, 7'd2, 1'b0, 4'h0, 1'b0);
        run_pid("t4_inverted", 3'd2, 0, -1, 0, 1'b1, 2);

        // Test 6: asynchronous reset mid-stream
        start(3'd0);
        repeat (2) @(posedge clk);
        #1 check("t6_valid_before", {31'b0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("t6_async_drop", {31'b0, out_valid}, 32'd0);
        check("t6_no_done", {31'b0, done}, 32'd0);
        $display("t6 reset mid-stream: out_valid=%0b done=%0b", out_valid, done);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("t6_start_ready", {31'b0, start_ready}, 32'd1);
        run_pid("t6_replay", 3'd0, 3, -1, 0, 1'b0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
